// File: rtl/instr_fetch_pkg.sv
// Shared encodings and word-PC arithmetic helpers for the instruction fetch unit.
package instr_fetch_pkg;

  typedef logic [0:0] fetch_state_t;

  localparam fetch_state_t FETCH_IDLE = 1'b0;
  localparam fetch_state_t FETCH_RUN  = 1'b1;

  // Explicit compare so the word count does not have to be a power of two.
  function automatic int unsigned pc_inc(input int unsigned pc, input int unsigned num);
    return (pc >= num - 1) ? 0 : pc + 1;
  endfunction

  function automatic int unsigned pc_wrap(input int unsigned addr, input int unsigned num);
    return addr % num;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read port plus decoder-side valid/ready port of the fetch unit.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH  = 7,
  parameter int INSTR_WIDTH = 32
);

  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  instr_addr;
  logic [INSTR_WIDTH-1:0] mem_instr;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;

  modport master (
    output rd_en, instr_addr, instr_valid, instr_out, instr_pc,
    input  mem_instr, instr_ready
  );

  modport slave (
    input  rd_en, instr_addr, instr_valid, instr_out, instr_pc,
    output mem_instr, instr_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small fall-through FIFO holding {instr, pc} pairs; synchronous clear drops all entries.
module instr_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 39
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != (PW+1)'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // The requester's credit check must never let a word arrive with nowhere to go.
  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      no_overflow: assert (!(push && !do_push));
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch requester: word PC, credit-limited memory reads, response capture
// into a small FIFO and valid/ready hand-off to the decoder, with redirect/squash.
//
// state      | meaning
// FETCH_IDLE | not issuing reads; in-flight word still captured
// FETCH_RUN  | issuing one read per cycle while credit allows
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_NUM    = 128,
  parameter int ADDR_WIDTH  = $clog2(ADDR_NUM),
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  fetch_busy,
  instr_fetch_if.master         bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t                       state;
  logic [ADDR_WIDTH-1:0]              pc;
  logic [ADDR_WIDTH-1:0]              resp_pc;
  logic                               resp_pending;
  logic [CW-1:0]                      count;
  logic                               pop;
  logic [CW:0]                        credit_used;
  logic                               head_valid;
  logic [INSTR_WIDTH+ADDR_WIDTH-1:0]  head_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_IDLE;
    end else begin
      case (state)
        FETCH_IDLE: if (fetch_en)  state <= FETCH_RUN;
        FETCH_RUN:  if (!fetch_en) state <= FETCH_IDLE;
      endcase
    end
  end

  assign pop = bus.instr_valid & bus.instr_ready;

  // Buffered words plus the one in flight must fit once this cycle's pop is taken.
  assign credit_used = (CW+1)'(count) + (CW+1)'(resp_pending) - (CW+1)'(pop);

  assign bus.rd_en = ~rst & (state == FETCH_RUN) & fetch_en & ~redirect_valid
                   & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.instr_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (redirect_valid) begin
      pc <= ADDR_WIDTH'(pc_wrap(32'(redirect_addr), ADDR_NUM));
    end else if (bus.rd_en) begin
      pc <= ADDR_WIDTH'(pc_inc(32'(pc), ADDR_NUM));
    end
  end

  // A redirect squashes the word that would land next cycle.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      resp_pending <= 1'b0;
      resp_pc      <= '0;
    end else begin
      resp_pending <= bus.rd_en;
      resp_pc      <= bus.instr_addr;
    end
  end

  instr_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_WIDTH + ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (redirect_valid),
    .push       (resp_pending),
    .push_data  ({bus.mem_instr, resp_pc}),
    .pop        (pop & ~redirect_valid),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign bus.instr_valid = head_valid;
  assign bus.instr_out   = head_data[INSTR_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign bus.instr_pc    = head_data[ADDR_WIDTH-1:0];

  assign fetch_busy = (count != '0) | resp_pending;

endmodule
